// File: rtl/readout_trigger_sched.sv
// Frame/row scheduler: turns FSYNC/R2S strobes into generator and recorder start pulses
// for a programmable row window, over a programmable number of frames.
module readout_trigger_sched #(
    parameter int ROW_W     = 10,
    parameter int FRAME_W   = 16,
    parameter int PULSE_LEN = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               fsync,
    input  logic               r2s,
    input  logic [ROW_W-1:0]   row_start,
    input  logic [ROW_W-1:0]   row_num,
    input  logic [FRAME_W-1:0] frames,
    input  logic               gen_busy,
    output logic               gen_start,
    output logic               rec_start,
    output logic               busy,
    output logic               done,
    output logic [ROW_W:0]     row_cnt,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic [7:0]         missed_cnt,
    output logic               sync_err
);

    // state        | meaning
    // S_IDLE       | waiting for an ENABLE rising edge
    // S_WAIT_FSYNC | run active, waiting for the next frame start
    // S_FRAME      | counting rows, issuing pulses inside the window
    // S_DONE       | requested frame count reached, held until ENABLE low
    typedef enum logic [1:0] {S_IDLE, S_WAIT_FSYNC, S_FRAME, S_DONE} state_t;

    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_LEN - 1);

    state_t             state, state_next;
    logic               enable_q;
    logic [ROW_W-1:0]   start_q, num_q;
    logic [FRAME_W-1:0] frames_q;
    logic [PW-1:0]      gen_left, rec_left;

    logic               start_ev, abort, fsync_ev, row_ev;
    logic               win_hit, rec_hit, last_row, gen_fire, gen_miss, run_done;
    logic [ROW_W:0]     num_eff, win_first, win_end;
    logic [FRAME_W-1:0] frame_nxt;

    always_comb begin
        num_eff   = (num_q == '0) ? (ROW_W+1)'(1) : {1'b0, num_q};
        win_first = {1'b0, start_q};
        win_end   = win_first + num_eff - (ROW_W+1)'(1);
        frame_nxt = frame_cnt + FRAME_W'(1);

        start_ev = (state == S_IDLE) && enable && !enable_q;
        abort    = !enable && ((state == S_WAIT_FSYNC) || (state == S_FRAME));
        fsync_ev = enable && fsync && ((state == S_WAIT_FSYNC) || (state == S_FRAME));
        // FSYNC wins over a coincident R2S
        row_ev   = (state == S_FRAME) && enable && r2s && !fsync;
        win_hit  = row_ev && (row_cnt >= win_first) && (row_cnt <= win_end);
        rec_hit  = row_ev && (row_cnt == win_first);
        last_row = row_ev && (row_cnt == win_end);
        gen_fire = win_hit && !gen_busy && !gen_start;
        gen_miss = win_hit && (gen_busy || gen_start);
        run_done = last_row && (frames_q != '0) && (frame_nxt == frames_q);
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:       if (start_ev) state_next = S_WAIT_FSYNC;
            S_WAIT_FSYNC: begin
                if (!enable)    state_next = S_IDLE;
                else if (fsync) state_next = S_FRAME;
            end
            S_FRAME: begin
                if (!enable)       state_next = S_IDLE;
                else if (fsync)    state_next = S_FRAME;
                else if (run_done) state_next = S_DONE;
                else if (last_row) state_next = S_WAIT_FSYNC;
            end
            S_DONE:       if (!enable) state_next = S_IDLE;
            default:      state_next = S_IDLE;
        endcase
    end

    // enable_q resets high so a level already present at reset release is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            enable_q <= 1'b1;
        end else begin
            state    <= state_next;
            enable_q <= enable;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            start_q    <= '0;
            num_q      <= '0;
            frames_q   <= '0;
            row_cnt    <= '0;
            frame_cnt  <= '0;
            missed_cnt <= '0;
            sync_err   <= 1'b0;
        end else begin
            busy <= (state_next == S_WAIT_FSYNC) || (state_next == S_FRAME);
            done <= (state_next == S_DONE);
            if (start_ev) begin
                start_q    <= row_start;
                num_q      <= row_num;
                frames_q   <= frames;
                row_cnt    <= '0;
                frame_cnt  <= '0;
                missed_cnt <= '0;
                sync_err   <= 1'b0;
            end else begin
                if (fsync_ev) begin
                    row_cnt <= '0;
                    if (state == S_FRAME) sync_err <= 1'b1;
                end else if (row_ev && (row_cnt != '1)) begin
                    row_cnt <= row_cnt + (ROW_W+1)'(1);
                end
                if (gen_miss && (missed_cnt != 8'hFF)) missed_cnt <= missed_cnt + 8'd1;
                if (last_row) frame_cnt <= frame_nxt;
            end
        end
    end

    // Start pulses: down-counters, released at zero; an abort clears them immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_start <= 1'b0;
            gen_left  <= '0;
            rec_start <= 1'b0;
            rec_left  <= '0;
        end else if (abort) begin
            gen_start <= 1'b0;
            gen_left  <= '0;
            rec_start <= 1'b0;
            rec_left  <= '0;
        end else begin
            if (gen_fire) begin
                gen_start <= 1'b1;
                gen_left  <= PULSE_LOAD;
            end else if (gen_start) begin
                if (gen_left == '0) gen_start <= 1'b0;
                else                gen_left  <= gen_left - PW'(1);
            end
            if (rec_hit) begin
                rec_start <= 1'b1;
                rec_left  <= PULSE_LOAD;
            end else if (rec_start) begin
                if (rec_left == '0) rec_start <= 1'b0;
                else                rec_left  <= rec_left - PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_readout_trigger_sched.sv
// Directed bench for readout_trigger_sched: expected pulse start cycles are queued when a
// strobe is driven and matched against observed rising edges of gen_start/rec_start.
module tb_readout_trigger_sched;

    localparam int ROW_W     = 10;
    localparam int FRAME_W   = 16;
    localparam int PULSE_LEN = 5;

    logic               clk = 1'b0;
    logic               rst_n, enable, fsync, r2s, gen_busy;
    logic [ROW_W-1:0]   row_start, row_num;
    logic [FRAME_W-1:0] frames;
    logic               gen_start, rec_start, busy, done, sync_err;
    logic [ROW_W:0]     row_cnt;
    logic [FRAME_W-1:0] frame_cnt;
    logic [7:0]         missed_cnt;

    int     vectors = 0;
    int     miscompares = 0;
    longint cyc = 0;
    longint gen_q[$];
    longint rec_q[$];
    longint gen_rise = 0, rec_rise = 0;
    logic   gen_prev = 1'b0, rec_prev = 1'b0;
    bit     len_chk = 1'b1;

    readout_trigger_sched #(.ROW_W(ROW_W), .FRAME_W(FRAME_W), .PULSE_LEN(PULSE_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fsync(fsync), .r2s(r2s),
        .row_start(row_start), .row_num(row_num), .frames(frames), .gen_busy(gen_busy),
        .gen_start(gen_start), .rec_start(rec_start), .busy(busy), .done(done),
        .row_cnt(row_cnt), .frame_cnt(frame_cnt), .missed_cnt(missed_cnt), .sync_err(sync_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input longint obs, input longint expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Pulse monitor: sampled 1 time unit after each active edge
    always @(posedge clk) begin
        #1;
        if (gen_start && !gen_prev) begin
            gen_rise = cyc;
            check("gen_pulse_expected", longint'(gen_q.size() != 0), 1);
            if (gen_q.size() != 0) check("gen_rise_cycle", cyc, gen_q.pop_front());
        end
        if (!gen_start && gen_prev && len_chk) check("gen_pulse_len", cyc - gen_rise, PULSE_LEN);
        if (rec_start && !rec_prev) begin
            rec_rise = cyc;
            check("rec_pulse_expected", longint'(rec_q.size() != 0), 1);
            if (rec_q.size() != 0) check("rec_rise_cycle", cyc, rec_q.pop_front());
        end
        if (!rec_start && rec_prev && len_chk) check("rec_pulse_len", cyc - rec_rise, PULSE_LEN);
        gen_prev = gen_start;
        rec_prev = rec_start;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; holds the strobe(s) for one cycle
    task automatic strobe(input bit f, input bit r, input bit exp_gen, input bit exp_rec);
        fsync = f;
        r2s   = r;
        if (exp_gen) gen_q.push_back(cyc + 1);
        if (exp_rec) rec_q.push_back(cyc + 1);
        @(negedge clk);
        fsync = 1'b0;
        r2s   = 1'b0;
    endtask

    // Starts a run, then scrambles the config inputs to confirm they were latched
    task automatic start_run(input int rs, input int rn, input int fr);
        enable    = 1'b0;
        row_start = ROW_W'(rs);
        row_num   = ROW_W'(rn);
        frames    = FRAME_W'(fr);
        idle(2);
        enable = 1'b1;
        idle(2);
        row_start = ~row_start;
        row_num   = ~row_num;
        frames    = ~frames;
        check("start_busy", busy, 1);
        check("start_cleared", {frame_cnt, missed_cnt, sync_err}, 0);
    endtask

    task automatic queues_empty(input string tag);
        check({tag, "_gen_q_left"}, gen_q.size(), 0);
        check({tag, "_rec_q_left"}, rec_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b1; enable = 1'b0; fsync = 1'b0; r2s = 1'b0; gen_busy = 1'b0;
        row_start = '0; row_num = '0; frames = '0;
        #1 rst_n = 1'b0;
        #2;
        check("reset_outputs", {gen_start, rec_start, busy, done, row_cnt, frame_cnt,
                                missed_cnt, sync_err}, 0);
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // 1: window rows 2..4 in one frame
        start_run(2, 3, 1);
        strobe(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            idle(50);
            strobe(0, 1, (i >= 2 && i <= 4), (i == 2));
        end
        idle(10);
        check("t1_done", done, 1);
        check("t1_busy", busy, 0);
        check("t1_frame_cnt", frame_cnt, 1);
        check("t1_row_cnt", row_cnt, 5);
        check("t1_missed", missed_cnt, 0);
        queues_empty("t1");

        // 2: generator busy across the window
        start_run(2, 3, 1);
        gen_busy = 1'b1;
        strobe(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            idle(50);
            strobe(0, 1, 0, (i == 2));
        end
        idle(10);
        gen_busy = 1'b0;
        check("t2_missed", missed_cnt, 3);
        check("t2_done", done, 1);
        queues_empty("t2");

        // 3: continuous mode, single-row window at row 0
        start_run(0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            strobe(1, 0, 0, 0);
            idle(2);
            strobe(0, 1, 1, 1);
            idle(6);
        end
        check("t3_frame_cnt", frame_cnt, 300);
        check("t3_done", done, 0);
        check("t3_busy", busy, 1);
        check("t3_row_cnt", row_cnt, 1);
        queues_empty("t3");

        // 4: early FSYNC restarts the window
        start_run(5, 1, 1);
        strobe(1, 0, 0, 0);
        idle(10); strobe(0, 1, 0, 0);
        idle(10); strobe(0, 1, 0, 0);
        idle(10); strobe(1, 0, 0, 0);
        check("t4_sync_err", sync_err, 1);
        check("t4_row_cnt_restart", row_cnt, 0);
        for (int i = 0; i < 6; i++) begin
            idle(10);
            strobe(0, 1, (i == 5), (i == 5));
        end
        idle(10);
        check("t4_frame_cnt", frame_cnt, 1);
        check("t4_done", done, 1);
        queues_empty("t4");

        // 5: coincident FSYNC+R2S, then abort during a pulse
        start_run(2, 2, 1);
        strobe(1, 0, 0, 0);
        idle(10); strobe(0, 1, 0, 0);
        idle(10); strobe(1, 1, 0, 0);
        idle(2);
        check("t5_row_cnt_dropped", row_cnt, 0);
        check("t5_sync_err", sync_err, 1);
        idle(10); strobe(0, 1, 0, 0);
        idle(10); strobe(0, 1, 0, 0);
        idle(10); strobe(0, 1, 1, 1);
        check("t5_gen_active", gen_start, 1);
        len_chk = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check("t5_abort_gen", gen_start, 0);
        check("t5_abort_rec", rec_start, 0);
        check("t5_abort_busy", busy, 0);
        check("t5_abort_done", done, 0);
        check("t5_abort_row_cnt", row_cnt, 3);
        idle(5);
        queues_empty("t5");

        // 6: async reset mid-frame, then enable level alone must not start a run
        start_run(0, 4, 0);
        strobe(1, 0, 0, 0);
        idle(10); strobe(0, 1, 1, 1);
        idle(10); strobe(1, 0, 0, 0);
        idle(10); strobe(0, 1, 1, 1);
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_reset_outputs", {gen_start, rec_start, busy, done, row_cnt, frame_cnt,
                                   missed_cnt, sync_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        strobe(1, 0, 0, 0);
        idle(3);
        check("t6_no_start_on_level", busy, 0);
        enable = 1'b0;
        idle(2);
        enable = 1'b1;
        idle(2);
        check("t6_start_on_edge", busy, 1);
        idle(5);
        queues_empty("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
